// File: rtl/lf_pid_nav.sv
// Line-follower navigation controller: sensor thresholding, node debounce,
// path-driven turn sequencing and a two-stage PID duty pipeline.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for en and a loaded path; duties held at 0
// TRACK | following the line with PID on the pattern error
// NODE  | all sensors on, debouncing a possible junction
// TURN  | executing a turn with a forced error until re-centred
// LOST  | line lost too long; duties 0, integral cleared
// DONE  | last path entry consumed; duties 0, path_done high
module lf_pid_nav #(
  parameter int N_SENS   = 3,
  parameter int ADC_W    = 12,
  parameter int THR      = 1200,
  parameter int ERR_W    = 9,
  parameter int ERR_STEP = 3,
  parameter int KP       = 4,
  parameter int KD       = 3,
  parameter int KI       = 0,
  parameter int ISUM_LIM = 30,
  parameter int BASE_PWM = 22,
  parameter int TURN_ERR = 6,
  parameter int NODE_DEB = 6,
  parameter int TURN_MIN = 4,
  parameter int LOST_LIM = 50,
  parameter int PATH_LEN = 10,
  localparam int CNT_W   = $clog2(PATH_LEN+1)
) (
  input  logic                    clk_50,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    sample_valid,
  input  logic [N_SENS*ADC_W-1:0] lsa,
  input  logic                    path_load,
  input  logic [2*PATH_LEN-1:0]   path,
  input  logic [CNT_W-1:0]        path_len,
  input  logic [1:0]              init_heading,
  output logic signed [ERR_W-1:0] duty_cycle1,
  output logic signed [ERR_W-1:0] duty_cycle2,
  output logic                    duty_valid,
  output logic signed [ERR_W-1:0] delta,
  output logic [CNT_W-1:0]        node_count,
  output logic [2:0]              state,
  output logic                    path_done
);
  localparam int WW = ERR_W + 8;
  localparam int LW = $clog2(LOST_LIM+1);
  localparam int DW = $clog2(NODE_DEB+1);
  localparam int TW = $clog2(TURN_MIN+1);

  localparam logic [ADC_W-1:0]        THR_W   = ADC_W'(THR);
  localparam logic [N_SENS-1:0]       CENTRE  = {{(N_SENS/2){1'b0}}, 1'b1, {(N_SENS/2){1'b0}}};
  localparam logic [LW-1:0]           LOST_LD = LW'(LOST_LIM);
  localparam logic [DW-1:0]           DEB_LD  = DW'(NODE_DEB-1);
  localparam logic [TW-1:0]           TURN_LD = TW'(TURN_MIN-1);
  localparam logic [CNT_W-1:0]        PLEN_MX = CNT_W'(PATH_LEN);
  localparam logic signed [ERR_W-1:0] TURN_E  = ERR_W'(TURN_ERR);
  localparam logic signed [ERR_W-1:0] MAX_E   = ERR_W'(2**(ERR_W-1)-1);
  localparam logic signed [WW-1:0]    MAX_W   = WW'(2**(ERR_W-1)-1);
  localparam logic signed [WW-1:0]    ISUM_W  = WW'(ISUM_LIM);
  localparam logic signed [WW-1:0]    KP_W    = WW'(KP);
  localparam logic signed [WW-1:0]    KD_W    = WW'(KD);
  localparam logic signed [WW-1:0]    KI_W    = WW'(KI);
  localparam logic signed [WW-1:0]    BASE_W  = WW'(BASE_PWM);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_TRACK = 3'd1, S_NODE = 3'd2,
    S_TURN = 3'd3, S_LOST = 3'd4, S_DONE = 3'd5
  } st_t;

  function automatic logic signed [WW-1:0] sx(input logic signed [ERR_W-1:0] v);
    return {{(WW-ERR_W){v[ERR_W-1]}}, v};
  endfunction

  function automatic logic signed [ERR_W-1:0] sat(input logic signed [WW-1:0] v);
    if (v > MAX_W)       return MAX_E;
    else if (v < -MAX_W) return -MAX_E;
    else                 return v[ERR_W-1:0];
  endfunction

  st_t                    st;
  logic [N_SENS-1:0]      pat;
  logic                   all_on, all_off, centre_only;
  int                     lo_idx, hi_idx;
  logic signed [ERR_W-1:0] pat_err;
  logic signed [ERR_W-1:0] err_q, prev_q, integ;
  logic                   ctr_q, s1_valid, path_ok;
  logic [2*PATH_LEN-1:0]  path_q;
  logic [CNT_W-1:0]       plen_q;
  logic [1:0]             heading, entry, rel;
  logic [LW-1:0]          lost_tmr;
  logic [DW-1:0]          deb_tmr;
  logic [TW-1:0]          turn_tmr;
  logic signed [WW-1:0]   e_w, diff_w, isum_w, ieff_w, raw_w, d_w;
  logic signed [ERR_W-1:0] int_nx, d_sat, dc1, dc2;

  assign state = st;

  // Threshold each sensor word into the on/off pattern.
  always_comb begin
    pat = '0;
    for (int i = 0; i < N_SENS; i++) pat[i] = lsa[i*ADC_W +: ADC_W] > THR_W;
  end

  // Line error from the outermost active sensors, plus node/turn lookups.
  always_comb begin
    lo_idx = 0;
    hi_idx = 0;
    for (int i = N_SENS-1; i >= 0; i--) if (pat[i]) lo_idx = i;
    for (int i = 0; i < N_SENS; i++) if (pat[i]) hi_idx = i;
    pat_err     = ERR_W'((lo_idx + hi_idx - (N_SENS-1)) * ERR_STEP);
    all_on      = &pat;
    all_off     = ~|pat;
    centre_only = (pat == CENTRE);
    entry       = path_q[{node_count, 1'b0} +: 2];
    rel         = entry - heading;
  end

  // Stage 1: path latch, navigation FSM and error selection.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      st         <= S_IDLE;
      err_q      <= '0;
      prev_q     <= '0;
      ctr_q      <= 1'b0;
      s1_valid   <= 1'b0;
      path_ok    <= 1'b0;
      path_q     <= '0;
      plen_q     <= '0;
      heading    <= 2'b00;
      node_count <= '0;
      path_done  <= 1'b0;
      lost_tmr   <= LOST_LD;
      deb_tmr    <= DEB_LD;
      turn_tmr   <= TURN_LD;
    end else begin
      s1_valid <= 1'b0;
      if (path_load && (st == S_IDLE || st == S_DONE)) begin
        // A load in the same cycle as a strobe swallows the sample.
        path_q     <= path;
        plen_q     <= (path_len > PLEN_MX) ? PLEN_MX : path_len;
        heading    <= init_heading;
        node_count <= '0;
        path_ok    <= (path_len != '0);
        st         <= S_IDLE;
        path_done  <= 1'b0;
      end else if (sample_valid) begin
        prev_q   <= err_q;
        ctr_q    <= centre_only;
        s1_valid <= 1'b1;
        if (!en) begin
          st        <= S_IDLE;
          path_done <= 1'b0;
          if (st == S_IDLE) s1_valid <= 1'b0;
        end else begin
          case (st)
            S_IDLE: begin
              if (path_ok) begin
                st       <= S_TRACK;
                lost_tmr <= LOST_LD;
                if (!all_on && !all_off) err_q <= pat_err;
              end else begin
                s1_valid <= 1'b0;
              end
            end
            S_TRACK: begin
              if (all_on) begin
                st      <= S_NODE;
                deb_tmr <= DEB_LD;
              end else if (all_off) begin
                if (lost_tmr == LW'(1)) begin
                  st       <= S_LOST;
                  lost_tmr <= LOST_LD;
                end else begin
                  lost_tmr <= lost_tmr - LW'(1);
                end
              end else begin
                err_q    <= pat_err;
                lost_tmr <= LOST_LD;
              end
            end
            S_NODE: begin
              if (!all_on) begin
                st       <= S_TRACK;
                lost_tmr <= LOST_LD;
              end else if (deb_tmr == DW'(1)) begin
                node_count <= node_count + CNT_W'(1);
                heading    <= entry;
                lost_tmr   <= LOST_LD;
                // Completing the path wins over any turn the entry encodes.
                if (node_count + CNT_W'(1) == plen_q) begin
                  st        <= S_DONE;
                  path_done <= 1'b1;
                end else if (rel == 2'd0) begin
                  st <= S_TRACK;
                end else begin
                  st       <= S_TURN;
                  turn_tmr <= TURN_LD;
                  err_q    <= (rel == 2'd3) ? -TURN_E : TURN_E;
                end
              end else begin
                deb_tmr <= deb_tmr - DW'(1);
              end
            end
            S_TURN: begin
              if (turn_tmr == '0) begin
                if (centre_only) begin
                  st       <= S_TRACK;
                  lost_tmr <= LOST_LD;
                end
              end else begin
                turn_tmr <= turn_tmr - TW'(1);
              end
            end
            S_LOST: begin
              if (!all_off) begin
                st       <= S_TRACK;
                lost_tmr <= LOST_LD;
                if (!all_on) err_q <= pat_err;
              end
            end
            S_DONE:  s1_valid <= 1'b0;
            default: st <= S_IDLE;
          endcase
        end
      end
    end
  end

  // PID arithmetic in the widened domain, saturated back to ERR_W.
  always_comb begin
    e_w    = sx(err_q);
    diff_w = e_w - sx(prev_q);
    isum_w = sx(integ) + e_w;
    if (isum_w > ISUM_W)       int_nx = ISUM_W[ERR_W-1:0];
    else if (isum_w < -ISUM_W) int_nx = -ISUM_W[ERR_W-1:0];
    else                       int_nx = isum_w[ERR_W-1:0];
    if (st == S_LOST || ctr_q) int_nx = '0;
    ieff_w = sx(int_nx);
    raw_w  = KP_W*e_w + KD_W*diff_w + KI_W*ieff_w;
    d_sat  = sat(raw_w);
    d_w    = sx(d_sat);
    dc1    = sat(BASE_W - d_w);
    dc2    = sat(BASE_W + d_w);
  end

  // Stage 2: register correction and duties, pulse duty_valid.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      delta       <= '0;
      duty_cycle1 <= '0;
      duty_cycle2 <= '0;
      duty_valid  <= 1'b0;
      integ       <= '0;
    end else begin
      duty_valid <= s1_valid;
      if (s1_valid) begin
        if (st == S_IDLE || st == S_DONE) begin
          delta       <= '0;
          duty_cycle1 <= '0;
          duty_cycle2 <= '0;
          integ       <= '0;
        end else begin
          delta       <= d_sat;
          integ       <= int_nx;
          duty_cycle1 <= (st == S_LOST) ? '0 : dc1;
          duty_cycle2 <= (st == S_LOST) ? '0 : dc2;
        end
      end
    end
  end
endmodule
